// File: rtl/crgu_pkg.sv
// Shared types and constants for the crgu power/clock sequencer.
// Step indices map one-to-one onto bits of the sequencer's control vector.
package crgu_pkg;

   typedef enum logic [2:0] {
      SEQ_OFF  = 3'd0,
      SEQ_UP   = 3'd1,
      SEQ_RUN  = 3'd2,
      SEQ_DOWN = 3'd3,
      SEQ_HOLD = 3'd4
   } seq_state_e;

   localparam logic [2:0] STEP_RSTN  = 3'd0;
   localparam logic [2:0] STEP_CLK   = 3'd1;
   localparam logic [2:0] STEP_DATA  = 3'd2;
   localparam logic [2:0] STEP_FIFO  = 3'd3;
   localparam logic [2:0] STEP_EFUSE = 3'd4;
   localparam logic [2:0] STEP_START = 3'd5;
   localparam int unsigned NUM_STEPS = 6;

   // Value a step drives when it fires: reset/clock steps are unconditional,
   // the optional steps follow their software enable {start, efuse, fifo, data}.
   function automatic logic step_val(input logic [2:0] idx, input logic [3:0] sw);
      logic v;
      v = 1'b1;
      case (idx)
         STEP_DATA:  v = sw[0];
         STEP_FIFO:  v = sw[1];
         STEP_EFUSE: v = sw[2];
         STEP_START: v = sw[3];
         default:    v = 1'b1;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/crgu_seq_ctrl.sv
// Purpose: always-on sequencer driving crgu reset/clock/domain enables in dwell-spaced order.
// Latency: step k rises (k+1)*DWELL cycles after UP entry; cmd_reset/RUN sw tracking take 1 cycle.
// Backpressure: none; req_on is a level, a drop mid-UP unwinds only the steps already fired.
module crgu_seq_ctrl
   import crgu_pkg::*;
#(
   parameter int unsigned DWELL    = 10,
   parameter int unsigned RST_HOLD = 10,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk_32k,
   input  logic       rst_32k_alon_n,
   input  logic       req_on,
   input  logic       sw_data_en,
   input  logic       sw_fifo_en,
   input  logic       sw_efuse_en,
   input  logic       sw_start,
   input  logic       cmd_reset,
   output logic       shut_rstn,
   output logic       clk_en,
   output logic       data_ctrl_en,
   output logic       rg_fifo_clk_en,
   output logic       rg_efuse_en,
   output logic       rg_top_start,
   output logic [2:0] seq_state,
   output logic       seq_busy
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RST_HOLD - 1);

   seq_state_e       state;
   logic [2:0]       step;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       ctl;
   logic [3:0]       sw_vec;

   assign sw_vec = {sw_start, sw_efuse_en, sw_fifo_en, sw_data_en};

   always_ff @(posedge clk_32k) begin
      if (!rst_32k_alon_n) begin
         state <= SEQ_OFF;
         step  <= '0;
         cnt   <= '0;
         ctl   <= '0;
      end else if (cmd_reset) begin
         state <= SEQ_HOLD;
         step  <= '0;
         cnt   <= '0;
         ctl   <= '0;
      end else begin
         case (state)
            SEQ_OFF: begin
               ctl  <= '0;
               step <= '0;
               cnt  <= '0;
               if (req_on) state <= SEQ_UP;
            end
            SEQ_UP: begin
               // step already equals the number of fired steps, so DOWN unwinds from here
               if (!req_on) begin
                  state <= SEQ_DOWN;
                  cnt   <= '0;
               end else if (cnt == DWELL_LAST) begin
                  ctl[step] <= step_val(step, sw_vec);
                  cnt       <= '0;
                  step      <= step + 3'd1;
                  if (step == STEP_START) state <= SEQ_RUN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SEQ_RUN: begin
               ctl[STEP_CLK:STEP_RSTN] <= 2'b11;
               if (!req_on) begin
                  state <= SEQ_DOWN;
                  step  <= 3'(NUM_STEPS);
                  cnt   <= '0;
               end else begin
                  ctl[STEP_START:STEP_DATA] <= sw_vec;
               end
            end
            SEQ_DOWN: begin
               if (step == 3'd0) begin
                  state <= SEQ_OFF;
               end else if (cnt == DWELL_LAST) begin
                  ctl[step - 3'd1] <= 1'b0;
                  step             <= step - 3'd1;
                  cnt              <= '0;
                  if (step == 3'd1) state <= SEQ_OFF;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SEQ_HOLD: begin
               ctl <= '0;
               if (cnt == HOLD_LAST) begin
                  state <= SEQ_OFF;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= SEQ_OFF;
               step  <= '0;
               cnt   <= '0;
               ctl   <= '0;
            end
         endcase
      end
   end

   assign shut_rstn      = ctl[STEP_RSTN];
   assign clk_en         = ctl[STEP_CLK];
   assign data_ctrl_en   = ctl[STEP_DATA];
   assign rg_fifo_clk_en = ctl[STEP_FIFO];
   assign rg_efuse_en    = ctl[STEP_EFUSE];
   assign rg_top_start   = ctl[STEP_START];

   assign seq_state = state;
   assign seq_busy  = (state == SEQ_UP) || (state == SEQ_DOWN) || (state == SEQ_HOLD);

endmodule

// File: doc/crgu_seq_ctrl.md
# crgu_seq_ctrl

Always-on power/clock sequencer in the 32 kHz domain that drives the `crgu` control inputs (`shut_rstn`, `clk_en`, `data_ctrl_en`, `rg_fifo_clk_en`, `rg_efuse_en`, `rg_top_start`) in a fixed, dwell-spaced order.
- On a power-up request it releases reset, enables clocks, then the optional domains, then start.
- On power-down it removes them in reverse order.
- A command reset forces everything off immediately and holds it off.

## Interface
Parameters:
- `DWELL`, 10: `clk_32k` cycles between consecutive sequence steps; must be ≥1.
- `RST_HOLD`, 10: cycles held in HOLD after `cmd_reset`; must be ≥1.
- `CNT_W`, 8: dwell/hold counter width; must hold `max(DWELL, RST_HOLD)`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
  - `clk_32k` in 1: always-on 32 kHz clock.
  - `rst_32k_alon_n` in 1: synchronous, active-low reset.
- Requests and commands:
  - `req_on` in 1: level power request; 1 = sequence up, 0 = sequence down.
  - `sw_data_en`, `sw_fifo_en`, `sw_efuse_en`, `sw_start` in 1 each: software enables for the optional steps.
  - `cmd_reset` in 1: one-cycle pulse, already synchronous to `clk_32k`.
- Outputs to `crgu`:
  - `shut_rstn`, `clk_en`, `data_ctrl_en`, `rg_fifo_clk_en`, `rg_efuse_en`, `rg_top_start` out 1 each: registered controls.
- Status:
  - `seq_state` out 3: OFF=0, UP=1, RUN=2, DOWN=3, HOLD=4.
  - `seq_busy` out 1: 1 in UP, DOWN or HOLD.

## Operation
- Step order, index 0..5: `shut_rstn`, `clk_en`, `data_ctrl_en`, `rg_fifo_clk_en`, `rg_efuse_en`, `rg_top_start`.
- Step values:
  - Steps 0–1 always drive 1.
  - Steps 2–5 drive the matching `sw_*` value sampled when the step fires.
  - Every step consumes its dwell even when its `sw_*` is 0.
- OFF:
  - All outputs 0.
  - `req_on`=1 → UP with `step`=0, `cnt`=0.
- UP:
  - `cnt` increments each cycle.
  - When `cnt`==DWELL-1: set output[`step`], `step`++, `cnt`=0.
  - When step 5 fires → RUN on the same edge.
  - `req_on`=0 → DOWN, `step` = number of steps already fired, `cnt`=0.
- RUN:
  - `shut_rstn` and `clk_en` held 1.
  - Outputs 2–5 track `sw_*` with 1-cycle latency.
  - `req_on`=0 → DOWN with `step`=6, `cnt`=0.
- DOWN:
  - Every DWELL cycles: `step`--, clear output[`step`].
  - After step 0 is cleared → OFF.
  - `req_on` rising during DOWN is ignored until OFF is reached; then re-UP.
  - If entered with `step`=0 → OFF on the next edge.
- HOLD:
  - All outputs 0.
  - Counts RST_HOLD cycles, then → OFF; OFF re-enters UP if `req_on`=1.
- `cmd_reset`:
  - From any state: all outputs 0 and → HOLD with `cnt`=0 on the next edge.
  - `cmd_reset` during HOLD restarts the count.
- Priority: `rst_32k_alon_n` > `cmd_reset` > `req_on` transitions > dwell stepping.

## Timing
- Reset: all six controls 0, `seq_state`=OFF, `seq_busy`=0, `step`=0, `cnt`=0, on the first `clk_32k` edge with `rst_32k_alon_n`=0.
- OFF→UP: one cycle after `req_on` is sampled 1.
- Step *k* (0-based) rises (k+1)·DWELL cycles after UP entry. With DWELL=10: `shut_rstn` @10, `rg_top_start` @60.
- DOWN: the n-th clear occurs n·DWELL cycles after DOWN entry.
- RUN tracking of `sw_*`: 1 cycle.
- `cmd_reset` → outputs 0: 1 cycle.
- All outputs are flop-driven; no combinational path from inputs to outputs.
- Counter never wraps; it reloads to 0 on each step and on each state entry.

## Structure
- Shared package `crgu_pkg`:
  - `seq_state_e` enum, 3 bits, with the encoding above.
  - Step index constants `STEP_RSTN`..`STEP_START`, and `NUM_STEPS`=6.
- Single module; no sub-module. The 6-bit output vector is indexed by `step`.

## Test plan
Unless noted: DWELL=10, RST_HOLD=10, all `sw_*`=1.
- Power-up: reset, then `req_on`=1 → `shut_rstn`, `clk_en`, `data_ctrl_en`, `rg_fifo_clk_en`, `rg_efuse_en`, `rg_top_start` rise at cycles 10/20/30/40/50/60 after UP entry; then `seq_state`=2, `seq_busy`=0.
- RUN tracking: `sw_efuse_en` 1→0 → `rg_efuse_en` 0 one cycle later, others unchanged; `sw_data_en`=0 at UP entry → `data_ctrl_en` stays 0, `rg_fifo_clk_en` still rises at cycle 40.
- Power-down: `req_on`=0 in RUN → clears at 10/20/30/40/50/60 in order `rg_top_start`→`shut_rstn`, then `seq_state`=0.
- Abort mid-UP: drop `req_on` at cycle 25 (`clk_en`=1) → `clk_en` clears 10 cycles later, `shut_rstn` 20 cycles later, then OFF.
- `cmd_reset` pulse in RUN with `req_on`=1 → all outputs 0 next cycle, `seq_state`=4 for 10 cycles, OFF, then UP again; a second pulse during HOLD extends HOLD by a full 10 cycles.
- `rst_32k_alon_n`=0 mid-UP → all outputs 0 and `seq_state`=0 at the next edge; release with `req_on`=1 → sequence restarts from step 0.
